// File: rtl/coin_acceptor.sv
// Coin-sensor front end: synchronise and debounce the sensor lines, classify each
// insertion, buffer accepted coins and release them as spaced single-cycle strobes.
`timescale 1ns/1ps
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int GAP      = 3,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] coin_sense,
  input  logic       cancel,
  output logic [7:0] coin,
  output logic       inputCoin,
  output logic       coin_reject,
  output logic [2:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0]    DEB_MAX  = 4'(DEBOUNCE);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);
  localparam logic [2:0]    FULL     = 3'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP} state_t;

  logic [3:0]    r_sync1, r_s, r_acc, r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_load, w_event, w_onehot, w_push, w_pop, w_reject;
  logic [7:0]    w_value, w_head;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic [2:0]    r_count;
  state_t        r_state, w_state_nxt;
  logic [3:0]    r_gap, w_gap_nxt;
  logic [7:0]    r_coin;
  logic          r_reject;

  // r_cnt is the number of consecutive identical samples of r_s, saturating.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_sync1 != r_s)      w_cnt_nxt = 4'd1;
    else if (r_cnt != DEB_MAX) w_cnt_nxt = r_cnt + 4'd1;
  end

  assign w_load   = (r_cnt == DEB_MAX) && (r_s != r_acc);
  assign w_event  = w_load && (r_acc == 4'd0) && (r_s != 4'd0);
  assign w_onehot = (r_s != 4'd0) && ((r_s & (r_s - 4'd1)) == 4'd0);

  always_comb begin
    w_value = 8'd0;
    case (r_s)
      4'b0001: w_value = 8'd1;
      4'b0010: w_value = 8'd5;
      4'b0100: w_value = 8'd10;
      4'b1000: w_value = 8'd50;
      default: w_value = 8'd0;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push   = w_event && !cancel && w_onehot && ((r_count != FULL) || w_pop);
  assign w_reject = w_event && !w_push;
  assign w_wr_nxt = (r_wr == LAST_PTR) ? '0 : r_wr + 1'b1;
  assign w_rd_nxt = (r_rd == LAST_PTR) ? '0 : r_rd + 1'b1;
  assign w_head   = r_mem[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_s     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= coin_sense;
      r_s     <= r_sync1;
      r_cnt   <= w_cnt_nxt;
      if (w_load) r_acc <= r_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (cancel) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_value;
        r_wr        <= w_wr_nxt;
      end
      if (w_pop) r_rd <= w_rd_nxt;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end

  // Strobe contract: inputCoin is high for exactly one cycle and coin is valid
  // in that cycle; there is no back-pressure, the GAP spacing is the only pacing.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != 3'd0) && !cancel) begin
          w_state_nxt = S_EMIT;
          w_pop       = 1'b1;
        end
      end
      S_EMIT: begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = 4'd0;
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          if ((r_count != 3'd0) && !cancel) begin
            w_state_nxt = S_EMIT;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gap    <= '0;
      r_coin   <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gap    <= w_gap_nxt;
      r_reject <= w_reject;
      if (w_pop) r_coin <= w_head;
    end
  end

  assign coin        = r_coin;
  assign inputCoin   = (r_state == S_EMIT);
  assign coin_reject = r_reject;
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: a default instance driven from a cycle table, and a
// slow-draining instance for burst, cancel-flush and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_coin_acceptor;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [3:0] cs_a, cs_b;
  logic       cancel_a, cancel_b;
  logic [7:0] coin_a, coin_b;
  logic       strobe_a, strobe_b, rej_a, rej_b;
  logic [2:0] cnt_a, cnt_b;

  coin_acceptor u_dut_a (
    .clk(clk), .reset(reset), .coin_sense(cs_a), .cancel(cancel_a),
    .coin(coin_a), .inputCoin(strobe_a), .coin_reject(rej_a), .fifo_count(cnt_a)
  );

  coin_acceptor #(.DEBOUNCE(2), .GAP(15), .DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .coin_sense(cs_b), .cancel(cancel_b),
    .coin(coin_b), .inputCoin(strobe_b), .coin_reject(rej_b), .fifo_count(cnt_b)
  );

  typedef struct {
    logic [3:0] cs;
    logic       cancel;
    logic [7:0] coin;
    logic       strobe;
    logic       rej;
    logic [2:0] cnt;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         gap_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_sb = -1;
  int         rej_b_n = 0;
  int         peak_b = 0;
  logic [7:0] tbl_coin = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // one clock edge, then sample 1ns later; instance B is monitored continuously
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (strobe_b) begin
      obs_q.push_back(coin_b);
      if (last_sb >= 0) gap_q.push_back(cyc - last_sb);
      last_sb = cyc;
    end
    if (rej_b) rej_b_n++;
    if (int'(cnt_b) > peak_b) peak_b = int'(cnt_b);
  endtask

  task automatic clear_mon();
    obs_q.delete();
    gap_q.delete();
    exp_q.delete();
    last_sb = -1;
    rej_b_n = 0;
    peak_b  = 0;
  endtask

  // 20-cycle table segment; vector k carries the inputs seen at edge k.
  // kind: 0 nothing, 1 accepted+strobed, 2 multi-bit reject,
  //       3 accepted then flushed by cancel at edge 7, 4 event dropped by cancel at edge 6
  task automatic seg(input logic [3:0] cs, input int hold, input int cancel_at,
                     input logic [7:0] val, input int kind);
    vec_t v;
    for (int k = 1; k <= 20; k++) begin
      v.cs     = (k <= hold) ? cs : 4'd0;
      v.cancel = (k == cancel_at);
      v.coin   = tbl_coin;
      v.strobe = 1'b0;
      v.rej    = 1'b0;
      v.cnt    = 3'd0;
      if ((kind == 1 || kind == 3) && k == 6) v.cnt = 3'd1;
      if ((kind == 2 || kind == 4) && k == 6) v.rej = 1'b1;
      if (kind == 1 && k >= 7) v.coin = val;
      if (kind == 1 && k == 7) v.strobe = 1'b1;
      vecs.push_back(v);
    end
    if (kind == 1) tbl_coin = val;
  endtask

  // driver for instance B: sensor level held 2 cycles, then 2 cycles low
  task automatic drop_b(input logic [3:0] cs);
    cs_b = cs;
    repeat (2) tick();
    cs_b = 4'd0;
    repeat (2) tick();
  endtask

  initial begin
    reset = 1'b1;
    cs_a = 4'd0; cs_b = 4'd0; cancel_a = 1'b0; cancel_b = 1'b0;

    seg(4'b0100, 10, 0, 8'd10, 1);
    seg(4'b0010,  3, 0, 8'd0,  0);
    seg(4'b0011, 10, 0, 8'd0,  2);
    seg(4'b1000, 10, 0, 8'd50, 1);
    seg(4'b0010,  4, 0, 8'd5,  1);
    seg(4'b0001,  5, 0, 8'd1,  1);
    seg(4'b0100, 10, 7, 8'd0,  3);
    seg(4'b0001, 10, 6, 8'd0,  4);
    seg(4'b1010, 10, 0, 8'd0,  2);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset.coin_a", coin_a, 0);
    chk("reset.strobe_a", strobe_a, 0);
    chk("reset.rej_a", rej_a, 0);
    chk("reset.cnt_a", cnt_a, 0);
    chk("reset.coin_b", coin_b, 0);
    chk("reset.cnt_b", cnt_b, 0);
    reset = 1'b0;
    repeat (8) tick();

    // table-driven vectors on instance A
    foreach (vecs[i]) begin
      cs_a     = vecs[i].cs;
      cancel_a = vecs[i].cancel;
      tick();
      chk($sformatf("vec%0d.coin", i), coin_a, vecs[i].coin);
      chk($sformatf("vec%0d.strobe", i), strobe_a, vecs[i].strobe);
      chk($sformatf("vec%0d.reject", i), rej_a, vecs[i].rej);
      chk($sformatf("vec%0d.count", i), cnt_a, vecs[i].cnt);
    end
    cs_a = 4'd0; cancel_a = 1'b0;

    // burst: 7 coins every 4 cycles into a 16-cycle strobe period
    clear_mon();
    repeat (6) exp_q.push_back(8'd50);
    repeat (7) drop_b(4'b1000);
    repeat (90) tick();
    chk("burst.strobes", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk("burst.coin", obs_q.pop_front(), exp_q.pop_front());
    chk("burst.rejects", rej_b_n, 1);
    chk("burst.peak", peak_b, 4);
    chk("burst.spacings", gap_q.size(), 5);
    foreach (gap_q[i]) chk($sformatf("burst.spacing%0d", i), gap_q[i], 16);
    chk("burst.drained", cnt_b, 0);

    // cancel flush with 3 coins buffered
    clear_mon();
    drop_b(4'b0001);
    drop_b(4'b0010);
    drop_b(4'b0100);
    drop_b(4'b1000);
    chk("cancel.before", cnt_b, 3);
    cancel_b = 1'b1;
    tick();
    cancel_b = 1'b0;
    chk("cancel.flush", cnt_b, 0);
    chk("cancel.coin_held", coin_b, 1);
    repeat (40) tick();
    chk("cancel.strobes", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("cancel.first_coin", obs_q[0], 1);
    chk("cancel.coin_after", coin_b, 1);
    chk("cancel.rejects", rej_b_n, 0);

    // asynchronous reset during GAP with 2 coins queued
    clear_mon();
    drop_b(4'b1000);
    drop_b(4'b1000);
    drop_b(4'b1000);
    chk("areset.queued", cnt_b, 2);
    chk("areset.coin_before", coin_b, 50);
    #3;
    reset = 1'b1;
    cs_b  = 4'b0100;
    #1;
    chk("areset.coin", coin_b, 0);
    chk("areset.strobe", strobe_b, 0);
    chk("areset.reject", rej_b, 0);
    chk("areset.count", cnt_b, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_mon();
    repeat (6) tick();
    cs_b = 4'd0;
    repeat (30) tick();
    chk("areset.strobes", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("areset.held_coin", obs_q[0], 10);
    chk("areset.count_end", cnt_b, 0);
    chk("areset.rejects", rej_b_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
